// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// ready/timeout memory handshake, branch resolution, retire counting and sticky fault.
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             BrEq,
    input  logic             BrLT,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             ir_en,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             reg_wen,
    output logic             mem_en,
    output logic             mem_rw,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam int unsigned       CNT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               fault_q;
    logic [RET_W-1:0]   ret_q;
    logic               timeout;
    logic               ir_en_raw, pc_en_raw, pc_sel_raw, reg_wen_raw, mem_en_raw, mem_rw_raw;

    assign timeout = (MEM_TIMEOUT != 0) && (wait_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        ir_en_raw   = 1'b0;
        pc_en_raw   = 1'b0;
        pc_sel_raw  = 1'b0;
        reg_wen_raw = 1'b0;
        mem_en_raw  = 1'b0;
        mem_rw_raw  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_en_raw = 1'b1;
                if (mem_ready) begin
                    ir_en_raw = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LD, OP_ST, OP_BR: state_d = S_EXEC;
                    default:                         state_d = S_FAULT;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_I:   state_d = S_WB;
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_BR: begin
                        // funct3[2] selects the BrLT flag, funct3[0] inverts the sense
                        if (funct3 == 3'b010 || funct3 == 3'b011) begin
                            state_d = S_FAULT;
                        end else begin
                            pc_en_raw  = 1'b1;
                            pc_sel_raw = (funct3[2] ? BrLT : BrEq) ^ funct3[0];
                            state_d    = S_FETCH;
                        end
                    end
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                mem_en_raw = 1'b1;
                mem_rw_raw = (opcode == OP_ST);
                if (mem_ready) begin
                    if (opcode == OP_ST) begin
                        pc_en_raw = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_wen_raw = 1'b1;
                pc_en_raw   = 1'b1;
                state_d     = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            fault_q <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_q | (state_d == S_FAULT);
            if (pc_en_raw) begin
                ret_q <= ret_q + RET_W'(1);
            end
        end
    end

    // Strobes are masked by rst so a mid-access reset drops them the same instant
    assign ir_en   = ir_en_raw   & ~rst;
    assign pc_en   = pc_en_raw   & ~rst;
    assign pc_sel  = pc_sel_raw  & ~rst;
    assign reg_wen = reg_wen_raw & ~rst;
    assign mem_en  = mem_en_raw  & ~rst;
    assign mem_rw  = mem_rw_raw  & ~rst;
    assign state   = state_q;
    assign fault   = fault_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer (MEM_TIMEOUT=4, RET_W=4).
module tb_core_sequencer;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       BrEq = 1'b0;
    logic       BrLT = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] state;
    logic       ir_en, pc_en, pc_sel, reg_wen, mem_en, mem_rw, fault;
    logic [3:0] retired;

    logic [8:0] obs;
    assign obs = {state, ir_en, pc_en, pc_sel, reg_wen, mem_en, mem_rw};

    int         checks = 0;
    int         passes = 0;
    logic [3:0] exp_ret = 4'd0;

    always #5 clk = ~clk;

    core_sequencer #(.MEM_TIMEOUT(4), .RET_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .BrEq(BrEq), .BrLT(BrLT),
        .mem_ready(mem_ready), .state(state), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel),
        .reg_wen(reg_wen), .mem_en(mem_en), .mem_rw(mem_rw), .fault(fault), .retired(retired)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({obs, fault, retired} !== 14'd0)
            $display("FAIL reset_hold: got %b, expected %b", {obs, fault, retired}, 14'd0);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 4'd0;
        #1;
        checks++;
        if ({state, fault, retired} !== 8'd0)
            $display("FAIL reset_release: got %b, expected %b", {state, fault, retired}, 8'd0);
        else passes++;
    endtask

    task automatic test_rtype();
        logic [8:0] e [4];
        e = '{{3'd0, 6'b100010}, {3'd1, 6'b000000}, {3'd2, 6'b000000}, {3'd4, 6'b010100}};
        opcode = OP_R; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== e[i]) $display("FAIL rtype_cyc%0d: got %b, expected %b", i, obs, e[i]);
            else passes++;
        end
        exp_ret++;
        @(posedge clk); #1;
        checks++;
        if ({state, retired} !== {3'd0, exp_ret})
            $display("FAIL rtype_retire: got %b, expected %b", {state, retired}, {3'd0, exp_ret});
        else passes++;
    endtask

    task automatic test_load();
        logic [8:0] e [8];
        logic       r [8];
        e = '{{3'd0, 6'b100010}, {3'd1, 6'b000000}, {3'd2, 6'b000000}, {3'd3, 6'b000010},
              {3'd3, 6'b000010}, {3'd3, 6'b000010}, {3'd3, 6'b000010}, {3'd4, 6'b010100}};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = OP_LD;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_ready = r[i];
            #1;
            checks++;
            if (obs !== e[i]) $display("FAIL load_cyc%0d: got %b, expected %b", i, obs, e[i]);
            else passes++;
        end
        exp_ret++;
        @(posedge clk); #1;
        checks++;
        if ({state, retired} !== {3'd0, exp_ret})
            $display("FAIL load_retire: got %b, expected %b", {state, retired}, {3'd0, exp_ret});
        else passes++;
    endtask

    task automatic test_store();
        logic [8:0] e [4];
        e = '{{3'd0, 6'b100010}, {3'd1, 6'b000000}, {3'd2, 6'b000000}, {3'd3, 6'b010011}};
        opcode = OP_ST; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== e[i]) $display("FAIL store_cyc%0d: got %b, expected %b", i, obs, e[i]);
            else passes++;
        end
        exp_ret++;
        @(posedge clk); #1;
        checks++;
        if ({state, retired} !== {3'd0, exp_ret})
            $display("FAIL store_retire: got %b, expected %b", {state, retired}, {3'd0, exp_ret});
        else passes++;
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic eq, input logic lt,
                               input logic exp_sel);
        logic [8:0] e [3];
        e = '{{3'd0, 6'b100010}, {3'd1, 6'b000000}, {3'd2, 1'b0, 1'b1, exp_sel, 3'b000}};
        opcode = OP_BR; funct3 = f3; BrEq = eq; BrLT = lt; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== e[i])
                $display("FAIL branch_f%b_eq%b_lt%b_cyc%0d: got %b, expected %b", f3, eq, lt, i, obs, e[i]);
            else passes++;
        end
        exp_ret++;
        @(posedge clk); #1;
        checks++;
        if ({state, retired} !== {3'd0, exp_ret})
            $display("FAIL branch_f%b_retire: got %b, expected %b", f3, {state, retired}, {3'd0, exp_ret});
        else passes++;
    endtask

    task automatic test_reset_mid_mem();
        logic [8:0] e [4];
        e = '{{3'd0, 6'b100010}, {3'd1, 6'b000000}, {3'd2, 6'b000000}, {3'd3, 6'b000010}};
        opcode = OP_LD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i < 3);
            #1;
            checks++;
            if (obs !== e[i]) $display("FAIL midrst_cyc%0d: got %b, expected %b", i, obs, e[i]);
            else passes++;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'd0) $display("FAIL midrst_strobes: got %b, expected %b", obs, 9'd0);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({state, fault, retired} !== 8'd0)
            $display("FAIL midrst_release: got %b, expected %b", {state, fault, retired}, 8'd0);
        else passes++;
        exp_ret = 4'd0;
    endtask

    task automatic test_wrap();
        opcode = OP_R; mem_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            repeat (4) @(negedge clk);
            @(posedge clk); #1;
            exp_ret++;
            checks++;
            if (retired !== exp_ret) $display("FAIL wrap_retire%0d: got %0d, expected %0d", k, retired, exp_ret);
            else passes++;
        end
        checks++;
        if (retired !== 4'd0) $display("FAIL wrap_zero: got %0d, expected 0", retired);
        else passes++;
    endtask

    task automatic test_branch_fault();
        logic [8:0] e [3];
        e = '{{3'd0, 6'b100010}, {3'd1, 6'b000000}, {3'd2, 6'b000000}};
        opcode = OP_BR; funct3 = 3'b010; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== e[i]) $display("FAIL brfault_cyc%0d: got %b, expected %b", i, obs, e[i]);
            else passes++;
        end
        @(posedge clk); #1;
        checks++;
        if ({state, fault, retired} !== {3'd5, 1'b1, exp_ret})
            $display("FAIL brfault_enter: got %b, expected %b", {state, fault, retired}, {3'd5, 1'b1, exp_ret});
        else passes++;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({obs, fault, retired} !== {3'd5, 6'b000000, 1'b1, exp_ret})
            $display("FAIL brfault_sticky: got %b, expected %b", {obs, fault, retired},
                     {3'd5, 6'b000000, 1'b1, exp_ret});
        else passes++;
    endtask

    task automatic test_illegal();
        opcode = OP_BAD; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (obs !== {3'd1, 6'b000000}) $display("FAIL illegal_decode: got %b, expected %b", obs, {3'd1, 6'b0});
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({obs, fault} !== {3'd5, 6'b000000, 1'b1})
            $display("FAIL illegal_fault: got %b, expected %b", {obs, fault}, {3'd5, 6'b0, 1'b1});
        else passes++;
    endtask

    task automatic test_timeout_fetch(input logic late_ready);
        opcode = OP_R;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = late_ready && (i == 3);
            #1;
            checks++;
            if (obs !== {3'd0, mem_ready, 5'b00010})
                $display("FAIL tofetch_r%b_cyc%0d: got %b, expected %b", late_ready, i, obs, {3'd0, mem_ready, 5'b00010});
            else passes++;
        end
        @(posedge clk); #1;
        checks++;
        if ({state, fault} !== (late_ready ? {3'd1, 1'b0} : {3'd5, 1'b1}))
            $display("FAIL tofetch_r%b_next: got %b, expected %b", late_ready, {state, fault},
                     (late_ready ? {3'd1, 1'b0} : {3'd5, 1'b1}));
        else passes++;
    endtask

    task automatic test_timeout_mem();
        opcode = OP_LD;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mem_ready = (i < 3);
            #1;
        end
        checks++;
        if (obs !== {3'd3, 6'b000010}) $display("FAIL tomem_last: got %b, expected %b", obs, {3'd3, 6'b000010});
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({state, fault, retired} !== {3'd5, 1'b1, exp_ret})
            $display("FAIL tomem_fault: got %b, expected %b", {state, fault, retired}, {3'd5, 1'b1, exp_ret});
        else passes++;
    endtask

    initial begin
        #2 rst = 1'b1;
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_branch(3'b001, 1'b0, 1'b0, 1'b1);
        test_branch(3'b001, 1'b1, 1'b0, 1'b0);
        test_branch(3'b000, 1'b1, 1'b0, 1'b1);
        test_branch(3'b101, 1'b0, 1'b0, 1'b1);
        test_branch(3'b110, 1'b0, 1'b0, 1'b0);
        test_reset_mid_mem();
        test_wrap();
        test_branch_fault();
        test_reset();
        test_illegal();
        test_reset();
        test_timeout_fetch(1'b0);
        test_reset();
        test_timeout_fetch(1'b1);
        test_reset();
        test_timeout_mem();
        test_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file and memory strobes. Memory accesses use a ready handshake with a timeout. It evaluates branches from the BrEq/BrLT comparator flags, counts retired instructions, and traps into a sticky FAULT state on an illegal opcode or a memory timeout.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for mem_ready per access; 0 disables the timeout.
RET_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  7  Inst[6:0] from IR; stable between ir_en pulses
funct3  input  3  Inst[14:12] from IR
BrEq  input  1  comparator: rs1 == rs2
BrLT  input  1  comparator: rs1 < rs2 (signedness chosen by datapath BrUn)
mem_ready  input  1  memory acknowledges the current access this cycle
state  output  3  current state encoding
ir_en  output  1  load IR
pc_en  output  1  update PC; one pulse per retired instruction
pc_sel  output  1  1 = branch target, 0 = PC+4; valid only when pc_en=1
reg_wen  output  1  register-file write enable
mem_en  output  1  memory access request
mem_rw  output  1  1 = write, 0 = read
fault  output  1  sticky trap flag
retired  output  RET_W  count of retired instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5. Codes 6 and 7 go to FAULT.
- Reset (rst high, asynchronous):
  - state=FETCH, wait counter=0, retired=0, fault=0.
  - All strobes (ir_en, pc_en, pc_sel, reg_wen, mem_en, mem_rw) forced to 0 while rst is high.
- Strobes are combinational from state and inputs; state, counters and fault are registered.
- FETCH:
  - mem_en=1, mem_rw=0.
  - mem_ready=1: ir_en=1 in the same cycle, next state DECODE.
  - mem_ready=0: stay in FETCH, wait counter increments.
- DECODE (1 cycle, no strobes):
  - Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011 → EXEC.
  - Any other opcode → FAULT.
- EXEC (1 cycle):
  - R-type (0110011) and I-type (0010011) → WB.
  - Load (0000011) and store (0100011) → MEM.
  - Branch (1100011):
    - funct3 000 BEQ: taken=BrEq. 001 BNE: taken=~BrEq. 100 BLT and 110 BLTU: taken=BrLT. 101 BGE and 111 BGEU: taken=~BrLT.
    - pc_en=1, pc_sel=taken, next state FETCH.
    - funct3 010 or 011: no strobes, next state FAULT.
- MEM:
  - mem_en=1; mem_rw=1 for a store, 0 for a load.
  - On mem_ready=1, a load goes to WB.
  - On mem_ready=1, a store asserts pc_en=1 (pc_sel=0) and goes to FETCH.
  - reg_wen is never asserted for stores.
- WB (1 cycle): reg_wen=1, pc_en=1, pc_sel=0, next state FETCH.
- Wait counter:
  - Cleared on every state change.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with mem_ready still 0, next state is FAULT. The access is therefore abandoned after exactly MEM_TIMEOUT non-ready cycles.
  - mem_ready arriving in that same cycle wins (normal progress).
- FAULT:
  - fault=1 and all strobes 0.
  - Remains in FAULT until rst; no other exit.
- retired:
  - Increments on every cycle with pc_en=1; wraps from 2^RET_W-1 to 0.
  - Never increments in FAULT.
- Latency with mem_ready always 1:
  - R/I-type = 4 cycles; load = 5 cycles; store = 4 cycles; branch = 3 cycles.
- Reset mid-access: state immediately returns to FETCH and mem_en drops the same instant. No partial writeback or pc_en occurs.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- R-type ADD (opcode 0110011), mem_ready tied 1: state sequence 0,1,2,4,0; reg_wen and pc_en high only in WB; retired 0→1 after 4 cycles.
- Load with mem_ready delayed 3 cycles in MEM: MEM held 4 cycles with mem_en=1, mem_rw=0; then WB with reg_wen=1; total 8 cycles; retired=1.
- Store: MEM cycle shows mem_en=1, mem_rw=1; pc_en=1 on the ready cycle; reg_wen never 1; 4 cycles total.
- Branch funct3=001 (BNE) with BrEq=0 → pc_en=1, pc_sel=1 in EXEC. Repeat with BrEq=1 → pc_sel=0. funct3=010 → FAULT, fault=1, retired unchanged.
- Faults:
  - opcode 0110111 → DECODE→FAULT, fault=1.
  - MEM_TIMEOUT=4 with mem_ready held 0 in FETCH → FAULT after exactly 4 FETCH cycles.
  - mem_ready=1 on the 4th cycle → DECODE instead.
- Reset and wrap:
  - rst pulsed mid-MEM → strobes 0 immediately; state=0, retired=0, fault=0 after release.
  - RET_W=4 after 16 retires → retired wraps to 0.
